// File: rtl/rq_scheduler_pkg.sv
// Shared constants and types for the request scheduler.
// RQ_WIDTH / TX_WIDTH : request-stream and engine TX-stream data widths.
// TX_BEATS_PER_PACKET : derived from the RX packet size so scheduler and engine agree.
package rq_scheduler_pkg;

  localparam int unsigned RQ_WIDTH            = 32;
  localparam int unsigned TX_WIDTH            = 256;
  localparam int unsigned RX_BEATS_PER_PACKET = 32;
  // Header + two TX beats per RX beat + footer.
  localparam int unsigned TX_BEATS_PER_PACKET = 2 * RX_BEATS_PER_PACKET + 2;
  localparam int unsigned CNT_W               = 5;

  typedef enum logic [0:0] {
    StArb,
    StOffer
  } state_e;

endpackage

// File: rtl/rq_scheduler_if.sv
// Bundle of all stream/status signals of rq_scheduler.
// slave  : scheduler view (consumes requester streams and TX monitor, drives engine request).
// master : environment view (requesters, engine, TX monitor tap).
interface rq_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  import rq_scheduler_pkg::*;

  logic [RQ_WIDTH*NUM_REQ-1:0] AXIS_IN_TDATA;
  logic [NUM_REQ-1:0]          AXIS_IN_TVALID;
  logic [NUM_REQ-1:0]          AXIS_IN_TREADY;
  logic [RQ_WIDTH-1:0]         AXIS_RQ_TDATA;
  logic                        AXIS_RQ_TVALID;
  logic                        AXIS_RQ_TREADY;
  logic                        TX_MON_TVALID;
  logic                        TX_MON_TREADY;
  logic [NUM_REQ-1:0]          DONE;
  logic [CNT_W-1:0]            OUTSTANDING;
  logic                        ERR;

  modport master (
    output AXIS_IN_TDATA, AXIS_IN_TVALID, AXIS_RQ_TREADY, TX_MON_TVALID, TX_MON_TREADY,
    input  AXIS_IN_TREADY, AXIS_RQ_TDATA, AXIS_RQ_TVALID, DONE, OUTSTANDING, ERR
  );

  modport slave (
    input  AXIS_IN_TDATA, AXIS_IN_TVALID, AXIS_RQ_TREADY, TX_MON_TVALID, TX_MON_TREADY,
    output AXIS_IN_TREADY, AXIS_RQ_TDATA, AXIS_RQ_TVALID, DONE, OUTSTANDING, ERR
  );

endinterface

// File: rtl/rq_scheduler_tag_fifo.sv
// rq_tag_fifo: small FIFO of requester tags for issued-but-uncompleted packets.
// clk, reset       : clock, synchronous active-high reset (empties the FIFO).
// push, push_data  : enqueue a tag; accepted when not full, or when full with a pop.
// pop, pop_data    : dequeue the head tag; pop_data shows the head, ignored when empty.
// empty            : no tags stored.
module rq_tag_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/rq_scheduler.sv
// rq_scheduler: round-robin merge of NUM_REQ request streams onto one registered request
// stream, with at most MAX_OUTSTANDING requests in flight. Completion is inferred by
// counting TX beats; each completed packet pulses DONE for the requester that issued it.
// clk, reset : clock, synchronous active-high reset.
// bus        : rq_scheduler_if.slave (requester inputs, engine request, TX tap, status).
module rq_scheduler #(
  parameter int unsigned NUM_REQ             = 4,
  parameter int unsigned MAX_OUTSTANDING     = 4,
  parameter int unsigned TX_BEATS_PER_PACKET = rq_scheduler_pkg::TX_BEATS_PER_PACKET
) (
  input logic           clk,
  input logic           reset,
  rq_scheduler_if.slave bus
);
  import rq_scheduler_pkg::*;

  localparam int unsigned TagW  = $clog2(NUM_REQ);
  localparam int unsigned BeatW = (TX_BEATS_PER_PACKET > 1) ? $clog2(TX_BEATS_PER_PACKET) : 1;

  state_e              state_q, state_d;
  logic [TagW-1:0]     last_grant_q, grant, cand, tag_out;
  logic                found, credit_ok, in_hs, rq_hs, tx_hs, pkt_done, tag_pop, fifo_empty;
  logic [NUM_REQ-1:0]  in_ready, done_q;
  logic [RQ_WIDTH-1:0] rq_tdata_q;
  logic                rq_tvalid_q, err_q;
  logic [CNT_W-1:0]    outstanding_q;
  logic [BeatW-1:0]    beat_q;

  // Registered count only: a completion this cycle frees credit next cycle.
  assign credit_ok = outstanding_q < CNT_W'(MAX_OUTSTANDING);

  // Round-robin search starting one past the last grant.
  always_comb begin
    found = 1'b0;
    grant = last_grant_q;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = TagW'((32'(last_grant_q) + k) % NUM_REQ);
      if (!found && bus.AXIS_IN_TVALID[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign in_hs    = (state_q == StArb) && credit_ok && found;
  assign rq_hs    = rq_tvalid_q & bus.AXIS_RQ_TREADY;
  assign tx_hs    = bus.TX_MON_TVALID & bus.TX_MON_TREADY;
  assign pkt_done = tx_hs && (beat_q == BeatW'(TX_BEATS_PER_PACKET - 1));
  assign tag_pop  = pkt_done & ~fifo_empty;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StArb;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StArb:   if (in_hs) state_d = StOffer;
      StOffer: if (rq_hs) state_d = StArb;
      default: state_d = StArb;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = '0;
    if ((state_q == StArb) && credit_ok && found) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rq_tdata_q    <= '0;
      rq_tvalid_q   <= 1'b0;
      last_grant_q  <= TagW'(NUM_REQ - 1);
      beat_q        <= '0;
      done_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      if (in_hs) begin
        rq_tdata_q   <= bus.AXIS_IN_TDATA[32'(grant) * RQ_WIDTH +: RQ_WIDTH];
        rq_tvalid_q  <= 1'b1;
        last_grant_q <= grant;
      end else if (rq_hs) begin
        rq_tvalid_q <= 1'b0;
      end
      if (tx_hs) beat_q <= pkt_done ? '0 : beat_q + BeatW'(1);
      done_q <= '0;
      if (tag_pop) done_q[tag_out] <= 1'b1;
      outstanding_q <= outstanding_q + CNT_W'(in_hs) - CNT_W'(tag_pop);
      // Completion with nothing recorded in flight: flag it, never underflow.
      if (pkt_done && fifo_empty) err_q <= 1'b1;
    end
  end

  rq_tag_fifo #(
    .Depth (MAX_OUTSTANDING),
    .Width (TagW)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_hs),
    .push_data (grant),
    .pop       (tag_pop),
    .pop_data  (tag_out),
    .empty     (fifo_empty)
  );

  assign bus.AXIS_IN_TREADY = in_ready;
  assign bus.AXIS_RQ_TDATA  = rq_tdata_q;
  assign bus.AXIS_RQ_TVALID = rq_tvalid_q;
  assign bus.DONE           = done_q;
  assign bus.OUTSTANDING    = outstanding_q;
  assign bus.ERR            = err_q;

endmodule

// File: tb/tb_rq_scheduler.sv
// Bench for rq_scheduler: u_dut (4 credits) covers most scenarios, u_dut2 (2 credits)
// covers the credit limit. Expected request data and DONE vectors are queued as stimulus
// is issued; negedge monitors pop and compare whenever the DUTs present them.
module tb_rq_scheduler;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rq_scheduler_if #(.NUM_REQ(4)) bus ();
  rq_scheduler_if #(.NUM_REQ(4)) bus2 ();

  rq_scheduler #(
    .NUM_REQ             (4),
    .MAX_OUTSTANDING     (4),
    .TX_BEATS_PER_PACKET (66)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  rq_scheduler #(
    .NUM_REQ             (4),
    .MAX_OUTSTANDING     (2),
    .TX_BEATS_PER_PACKET (66)
  ) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_rq[$];
  logic [31:0] exp_rq2[$];
  logic [3:0]  exp_done[$];
  logic [3:0]  exp_done2[$];

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endfunction

  function automatic void unexpected(input string name, input logic [31:0] got);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %h, expected nothing", name, got);
  endfunction

  // Monitors
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.AXIS_RQ_TVALID && bus.AXIS_RQ_TREADY) begin
        if (exp_rq.size() == 0) unexpected("rq_extra", bus.AXIS_RQ_TDATA);
        else check("rq_data", bus.AXIS_RQ_TDATA, exp_rq.pop_front());
      end
      if (bus.DONE != 4'b0) begin
        if (exp_done.size() == 0) unexpected("done_extra", 32'(bus.DONE));
        else check("done_vec", 32'(bus.DONE), 32'(exp_done.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus2.AXIS_RQ_TVALID && bus2.AXIS_RQ_TREADY) begin
        if (exp_rq2.size() == 0) unexpected("rq2_extra", bus2.AXIS_RQ_TDATA);
        else check("rq2_data", bus2.AXIS_RQ_TDATA, exp_rq2.pop_front());
      end
      if (bus2.DONE != 4'b0) begin
        if (exp_done2.size() == 0) unexpected("done2_extra", 32'(bus2.DONE));
        else check("done2_vec", 32'(bus2.DONE), 32'(exp_done2.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Waits (bounded) for any TREADY, checks it is the expected one-hot, then lets the
  // handshake happen and returns just after that edge.
  task automatic wait_grant(input string name, input logic [3:0] exp_rdy, input bit sel2);
    int t = 0;
    logic [3:0] rdy;
    @(negedge clk);
    rdy = sel2 ? bus2.AXIS_IN_TREADY : bus.AXIS_IN_TREADY;
    while (rdy == 4'b0 && t < 200) begin
      @(negedge clk);
      rdy = sel2 ? bus2.AXIS_IN_TREADY : bus.AXIS_IN_TREADY;
      t++;
    end
    check(name, 32'(rdy), 32'(exp_rdy));
    tick();
  endtask

  task automatic tx_beats(input int n, input bit sel2);
    if (sel2) begin bus2.TX_MON_TVALID = 1'b1; bus2.TX_MON_TREADY = 1'b1; end
    else      begin bus.TX_MON_TVALID  = 1'b1; bus.TX_MON_TREADY  = 1'b1; end
    repeat (n) @(posedge clk);
    #1;
    bus.TX_MON_TVALID  = 1'b0; bus.TX_MON_TREADY  = 1'b0;
    bus2.TX_MON_TVALID = 1'b0; bus2.TX_MON_TREADY = 1'b0;
  endtask

  initial begin
    bus.AXIS_IN_TDATA  = '0; bus.AXIS_IN_TVALID  = '0; bus.AXIS_RQ_TREADY  = 1'b0;
    bus.TX_MON_TVALID  = 1'b0; bus.TX_MON_TREADY = 1'b0;
    bus2.AXIS_IN_TDATA = '0; bus2.AXIS_IN_TVALID = '0; bus2.AXIS_RQ_TREADY = 1'b0;
    bus2.TX_MON_TVALID = 1'b0; bus2.TX_MON_TREADY = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_tready", 32'(bus.AXIS_IN_TREADY), 32'h0);
    check("rst_rq_tvalid", 32'(bus.AXIS_RQ_TVALID), 32'h0);
    check("rst_rq_tdata", bus.AXIS_RQ_TDATA, 32'h0);
    check("rst_done", 32'(bus.DONE), 32'h0);
    check("rst_outstanding", 32'(bus.OUTSTANDING), 32'h0);
    check("rst_err", 32'(bus.ERR), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single request from requester 2
    bus.AXIS_RQ_TREADY = 1'b1;
    bus.AXIS_IN_TDATA[95:64] = 32'h0000_00A5;
    bus.AXIS_IN_TVALID = 4'b0100;
    exp_rq.push_back(32'h0000_00A5);
    wait_grant("single_grant", 4'b0100, 1'b0);
    bus.AXIS_IN_TVALID = 4'b0000;
    @(negedge clk);
    check("single_rq_tvalid", 32'(bus.AXIS_RQ_TVALID), 32'h1);
    check("single_rq_tdata", bus.AXIS_RQ_TDATA, 32'h0000_00A5);
    check("single_outstanding", 32'(bus.OUTSTANDING), 32'h1);
    tick();
    exp_done.push_back(4'b0100);
    tx_beats(66, 1'b0);
    @(negedge clk);
    check("single_done", 32'(bus.DONE), 32'h4);
    check("single_outstanding_0", 32'(bus.OUTSTANDING), 32'h0);
    @(negedge clk);
    check("single_done_pulse", 32'(bus.DONE), 32'h0);
    tick();

    // Fairness: all four valid continuously, grants 0,1,2,3,0,1
    do_reset();
    for (int k = 0; k < 6; k++) exp_rq.push_back(32'hF000_0000 | ((k % 4) << 8) | (k / 4));
    exp_done.push_back(4'b0001); exp_done.push_back(4'b0010);
    exp_done.push_back(4'b0100); exp_done.push_back(4'b1000);
    exp_done.push_back(4'b0001); exp_done.push_back(4'b0010);
    for (int i = 0; i < 4; i++) bus.AXIS_IN_TDATA[i*32 +: 32] = 32'hF000_0000 | (i << 8);
    bus.AXIS_IN_TVALID = 4'b1111;
    fork
      tx_beats(396, 1'b0);
      begin
        for (int k = 0; k < 6; k++) begin
          wait_grant($sformatf("fair_grant%0d", k), 4'(1 << (k % 4)), 1'b0);
          bus.AXIS_IN_TDATA[(k % 4)*32 +: 32] = 32'hF000_0000 | ((k % 4) << 8) | (k / 4 + 1);
        end
        bus.AXIS_IN_TVALID = 4'b0000;
      end
    join
    @(negedge clk);
    check("fair_outstanding", 32'(bus.OUTSTANDING), 32'h0);
    check("fair_err", 32'(bus.ERR), 32'h0);
    tick();

    // Backpressure: engine not ready for 10 cycles
    bus.AXIS_RQ_TREADY = 1'b0;
    bus.AXIS_IN_TDATA[63:32] = 32'h1111_0001;
    bus.AXIS_IN_TVALID = 4'b0010;
    exp_rq.push_back(32'h1111_0001);
    exp_rq.push_back(32'h3333_0003);
    wait_grant("bp_grant", 4'b0010, 1'b0);
    bus.AXIS_IN_TDATA[127:96] = 32'h3333_0003;
    bus.AXIS_IN_TVALID = 4'b1000;
    repeat (10) begin
      @(negedge clk);
      check("bp_tvalid", 32'(bus.AXIS_RQ_TVALID), 32'h1);
      check("bp_tdata", bus.AXIS_RQ_TDATA, 32'h1111_0001);
      check("bp_in_tready", 32'(bus.AXIS_IN_TREADY), 32'h0);
    end
    tick();
    bus.AXIS_RQ_TREADY = 1'b1;
    wait_grant("bp_next_grant", 4'b1000, 1'b0);
    bus.AXIS_IN_TVALID = 4'b0000;

    // Issue and completion in the same cycle at OUTSTANDING = 2 (tags 1,3 queued)
    tx_beats(65, 1'b0);
    exp_rq.push_back(32'h0000_0A0A);
    exp_done.push_back(4'b0010); exp_done.push_back(4'b1000); exp_done.push_back(4'b0001);
    bus.AXIS_IN_TDATA[31:0] = 32'h0000_0A0A;
    bus.AXIS_IN_TVALID = 4'b0001;
    bus.TX_MON_TVALID = 1'b1; bus.TX_MON_TREADY = 1'b1;
    @(negedge clk);
    check("simul_grant", 32'(bus.AXIS_IN_TREADY), 32'h1);
    check("simul_outstanding_pre", 32'(bus.OUTSTANDING), 32'h2);
    tick();
    bus.AXIS_IN_TVALID = 4'b0000;
    bus.TX_MON_TVALID = 1'b0; bus.TX_MON_TREADY = 1'b0;
    @(negedge clk);
    check("simul_outstanding", 32'(bus.OUTSTANDING), 32'h2);
    check("simul_done", 32'(bus.DONE), 32'h2);
    tick();
    tx_beats(66, 1'b0);
    @(negedge clk);
    check("order_done_3", 32'(bus.DONE), 32'h8);
    tick();
    tx_beats(66, 1'b0);
    @(negedge clk);
    check("order_done_0", 32'(bus.DONE), 32'h1);
    check("order_outstanding", 32'(bus.OUTSTANDING), 32'h0);
    tick();

    // Error: a packet completes with nothing in flight
    tx_beats(66, 1'b0);
    @(negedge clk);
    check("err_set", 32'(bus.ERR), 32'h1);
    check("err_outstanding", 32'(bus.OUTSTANDING), 32'h0);
    tick();

    // Reset mid-packet with one request in flight
    bus.AXIS_IN_TDATA[127:96] = 32'h3333_0099;
    bus.AXIS_IN_TVALID = 4'b1000;
    exp_rq.push_back(32'h3333_0099);
    wait_grant("pre_reset_grant", 4'b1000, 1'b0);
    bus.AXIS_IN_TVALID = 4'b0000;
    tx_beats(30, 1'b0);
    do_reset();
    @(negedge clk);
    check("reset_err", 32'(bus.ERR), 32'h0);
    check("reset_outstanding", 32'(bus.OUTSTANDING), 32'h0);
    check("reset_rq_tvalid", 32'(bus.AXIS_RQ_TVALID), 32'h0);
    tick();
    bus.AXIS_IN_TDATA[31:0]  = 32'h0000_0C00;
    bus.AXIS_IN_TDATA[63:32] = 32'h0000_0C01;
    bus.AXIS_IN_TVALID = 4'b0011;
    exp_rq.push_back(32'h0000_0C00);
    wait_grant("post_reset_grant", 4'b0001, 1'b0);
    bus.AXIS_IN_TVALID = 4'b0000;
    tx_beats(65, 1'b0);
    @(negedge clk);
    check("no_early_wrap", 32'(bus.DONE), 32'h0);
    check("post_reset_outstanding", 32'(bus.OUTSTANDING), 32'h1);
    tick();
    exp_done.push_back(4'b0001);
    tx_beats(1, 1'b0);
    @(negedge clk);
    check("post_reset_done", 32'(bus.DONE), 32'h1);
    check("post_reset_err", 32'(bus.ERR), 32'h0);
    tick();

    // Credit limit on the two-credit instance
    bus2.AXIS_RQ_TREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus2.AXIS_IN_TDATA[i*32 +: 32] = 32'h0200_0000 | i;
      exp_rq2.push_back(32'h0200_0000 | i);
    end
    exp_done2.push_back(4'b0001); exp_done2.push_back(4'b0010); exp_done2.push_back(4'b0100);
    bus2.AXIS_IN_TVALID = 4'b0111;
    wait_grant("credit_grant0", 4'b0001, 1'b1);
    bus2.AXIS_IN_TVALID = 4'b0110;
    wait_grant("credit_grant1", 4'b0010, 1'b1);
    bus2.AXIS_IN_TVALID = 4'b0100;
    repeat (10) begin
      @(negedge clk);
      check("credit_stall", 32'(bus2.AXIS_IN_TREADY), 32'h0);
      check("credit_outstanding", 32'(bus2.OUTSTANDING), 32'h2);
    end
    tick();
    tx_beats(66, 1'b1);
    @(negedge clk);
    check("credit_release", 32'(bus2.AXIS_IN_TREADY), 32'h4);
    check("credit_outstanding_1", 32'(bus2.OUTSTANDING), 32'h1);
    tick();
    bus2.AXIS_IN_TVALID = 4'b0000;
    tx_beats(132, 1'b1);
    @(negedge clk);
    check("credit_drained", 32'(bus2.OUTSTANDING), 32'h0);
    check("credit_err", 32'(bus2.ERR), 32'h0);
    tick();
    repeat (3) tick();

    check("rq_queue_drained", 32'(exp_rq.size() + exp_rq2.size()), 32'h0);
    check("done_queue_drained", 32'(exp_done.size() + exp_done2.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rq_scheduler.md
# rq_scheduler

Round-robin scheduler that merges data-request streams from NUM_REQ requesters into the single 32-bit request stream consumed by the row-transmit engine. It limits the number of requests in flight to MAX_OUTSTANDING. It counts beats on the engine's 256-bit TX output to detect packet completion, and signals completion back to the requester that issued each packet.

## Interface
- NUM_REQ, 4: number of requester streams (2..8).
- MAX_OUTSTANDING, 4: maximum issued-but-uncompleted requests (1..16).
- TX_BEATS_PER_PACKET, 66: TX beats per packet (1 header + 64 data + 1 footer).
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- AXIS_IN_TDATA  in  32*NUM_REQ  request ID per requester; requester i occupies bits [32i+31:32i].
- AXIS_IN_TVALID  in  NUM_REQ  per-requester valid.
- AXIS_IN_TREADY  out  NUM_REQ  per-requester ready; at most one bit high per cycle.
- AXIS_RQ_TDATA  out  32  registered request to the engine.
- AXIS_RQ_TVALID  out  1  registered valid.
- AXIS_RQ_TREADY  in  1  engine ready.
- TX_MON_TVALID  in  1  monitor tap of the engine TX valid.
- TX_MON_TREADY  in  1  monitor tap of the engine TX ready.
- DONE  out  NUM_REQ  one-cycle pulse on bit i when a packet for requester i completes.
- OUTSTANDING  out  5  current in-flight count.
- ERR  out  1  sticky; set when a packet completes with no request recorded as in flight.

## Operation
- States:
  - S_ARB: arbitrate requesters.
  - S_OFFER: hold the request on AXIS_RQ until the engine accepts it.
- S_ARB, grant rule:
  - credit_ok = OUTSTANDING < MAX_OUTSTANDING.
  - Search starts at requester (last_grant+1) mod NUM_REQ and wraps; the first requester with TVALID high wins.
  - AXIS_IN_TREADY[g] is combinational: high only for the winner, only in S_ARB, only when credit_ok.
- On the input handshake:
  - AXIS_RQ_TDATA <= AXIS_IN_TDATA[g]; AXIS_RQ_TVALID <= 1.
  - Push g into the tag FIFO.
  - OUTSTANDING increments; last_grant <= g.
  - Go to S_OFFER.
- S_OFFER: on AXIS_RQ_TVALID & AXIS_RQ_TREADY, clear TVALID and return to S_ARB.
- Completion tracking:
  - A beat counter (0..TX_BEATS_PER_PACKET-1) increments on each TX_MON_TVALID & TX_MON_TREADY.
  - On the handshake at count TX_BEATS_PER_PACKET-1, the counter wraps to 0 and one packet is complete.
  - If the tag FIFO is non-empty: pop tag t, DONE[t] pulses the next cycle, OUTSTANDING decrements.
  - If the tag FIFO is empty: set ERR; OUTSTANDING is unchanged and does not underflow.
- Packets complete in issue order, because the engine serves requests FIFO.
- An issue and a completion in the same cycle leave OUTSTANDING unchanged; the FIFO pushes and pops simultaneously, and this is legal when full.
- credit_ok uses the registered OUTSTANDING, so a completion in the same cycle does not release credit until the next cycle.

## Timing
- Reset values:
  - AXIS_IN_TREADY = 0 and AXIS_RQ_TVALID = 0.
  - AXIS_RQ_TDATA = 0, DONE = 0, OUTSTANDING = 0, ERR = 0.
  - Beat counter = 0, tag FIFO empty.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - State = S_ARB.
- Latency:
  - Input handshake at cycle N puts AXIS_RQ_TVALID high at N+1.
  - With the engine always ready, the next grant is possible at N+2.
  - Peak throughput is one request per 2 cycles.
- AXIS_RQ_TDATA is stable while TVALID is high and not yet accepted.
- The final TX handshake of a packet at cycle M produces a DONE pulse at M+1 and OUTSTANDING updated at M+1.
- Reset asserted mid-operation:
  - All in-flight state is discarded, including the beat count and FIFO contents.
  - The engine must be reset alongside this block.
- TX beats observed while OUTSTANDING is 0 still count; the wrap is what sets ERR.

## Structure
- The shared package/header holds:
  - RQ_WIDTH = 32 and TX_WIDTH = 256.
  - RX_BEATS_PER_PACKET = 32.
  - TX_BEATS_PER_PACKET = 2*RX_BEATS_PER_PACKET + 2, so this block and the engine cannot diverge.
- The tag FIFO is the natural sub-module: rq_tag_fifo, depth MAX_OUTSTANDING, width clog2(NUM_REQ), with simultaneous push/pop when full.
- The round-robin grant stays inline as combinational logic.

## Test plan
- Single request: requester 2 sends 0x0000_00A5 with the engine always ready.
  - AXIS_RQ carries 0xA5 one cycle after the input handshake.
  - After 66 TX handshakes, DONE = 4'b0100 for one cycle and OUTSTANDING returns to 0.
- Fairness: all 4 requesters hold valid continuously with MAX_OUTSTANDING = 16.
  - Grants go 0,1,2,3,0,1,… in that order.
  - No requester gets two grants before the others each get one.
- Credit limit with MAX_OUTSTANDING = 2: three requests pending and no TX traffic.
  - Exactly 2 are issued and the third stays stalled (AXIS_IN_TREADY low).
  - The third issues only after the first 66-beat packet completes.
- Backpressure: AXIS_RQ_TREADY is held low for 10 cycles.
  - AXIS_RQ_TDATA and TVALID are stable throughout.
  - No further AXIS_IN_TREADY is asserted until acceptance.
- Simultaneous issue and completion: at OUTSTANDING = 2, the 66th TX beat lands in the same cycle as an input handshake.
  - OUTSTANDING stays 2.
  - DONE pulses for the oldest tag.
  - The FIFO order is preserved.
- Error and reset:
  - 66 TX beats with nothing outstanding set ERR and leave OUTSTANDING at 0.
  - Reset mid-packet clears ERR, the beat count and the FIFO.
  - The next grant after reset goes to requester 0.
